// File: rtl/tug_of_war_core.sv
// tug_of_war_core: N-light tug-of-war game engine with edge-detected button
// presses, per-player round scores, timed round restart and a match-over latch.
// Optional feature macro: TOW_CPU_EN (right player driven by an LFSR opponent).
`timescale 1ns/1ps

module tug_of_war_core #(
  parameter int unsigned N_LIGHTS    = 9,
  parameter int unsigned SCORE_W     = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CPU_DIV_W   = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                l_in,
  input  logic                r_in,
  input  logic [9:0]          cpu_speed,
  output logic [N_LIGHTS-1:0] lights,
  output logic                left_win,
  output logic                right_win,
  output logic [SCORE_W-1:0]  left_score,
  output logic [SCORE_W-1:0]  right_score,
  output logic                match_over
);

  localparam int unsigned POS_W  = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [POS_W-1:0]   POS_C     = POS_W'((N_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(N_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLAY,
    S_WIN_L,
    S_WIN_R,
    S_OVER
  } state_e;

  state_e              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SCORE_W-1:0]  left_score_q, left_score_d;
  logic [SCORE_W-1:0]  right_score_q, right_score_d;
  logic                left_win_q, left_win_d;
  logic                right_win_q, right_win_d;
  logic                match_over_q, match_over_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic                l_q, l_d;
  logic                r_q, r_d;
  logic                r_eff;
  logic                pl;
  logic                pr;

`ifdef TOW_CPU_EN
  logic [9:0]           lfsr_q, lfsr_d;
  logic [CPU_DIV_W-1:0] div_q, div_d;
  logic                 cpu_press;
  logic                 unused_r_in;

  // LFSR (taps 10,7) and prescaler advance every cycle; CPU presses on wrap
  always_comb begin
    lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    div_d     = div_q + CPU_DIV_W'(1);
    cpu_press = (&div_q) && (lfsr_q < cpu_speed);
  end

  // CPU opponent state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 10'h001;
      div_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      div_q  <= div_d;
    end
  end

  assign r_eff       = cpu_press;
  assign unused_r_in = r_in;
`else
  logic unused_cpu;

  assign r_eff      = r_in;
  assign unused_cpu = ^{cpu_speed, CPU_DIV_W'(0)};
`endif

  // Game FSM: press detection, rope movement, scoring and hold timing
  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    hold_d        = hold_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    left_win_d    = left_win_q;
    right_win_d   = right_win_q;
    match_over_d  = match_over_q;
    l_d           = l_in;
    r_d           = r_eff;
    pl            = l_in & ~l_q;
    pr            = r_eff & ~r_q;

    case (state_q)
      S_PLAY: begin
        if (pl && !pr) begin
          if (pos_q == POS_MAX) begin
            state_d      = S_WIN_L;
            left_score_d = left_score_q + SCORE_W'(1);
            left_win_d   = 1'b1;
            hold_d       = HOLD_LOAD;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else if (pr && !pl) begin
          if (pos_q == '0) begin
            state_d       = S_WIN_R;
            right_score_d = right_score_q + SCORE_W'(1);
            right_win_d   = 1'b1;
            hold_d        = HOLD_LOAD;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
      end
      S_WIN_L: begin
        if (hold_q == '0) begin
          if (left_score_q == SCORE_MAX) begin
            state_d      = S_OVER;
            match_over_d = 1'b1;
          end else begin
            state_d    = S_PLAY;
            pos_d      = POS_C;
            left_win_d = 1'b0;
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_WIN_R: begin
        if (hold_q == '0) begin
          if (right_score_q == SCORE_MAX) begin
            state_d      = S_OVER;
            match_over_d = 1'b1;
          end else begin
            state_d     = S_PLAY;
            pos_d       = POS_C;
            right_win_d = 1'b0;
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_PLAY;
      end
    endcase

    lights_d = (state_d == S_PLAY) ? (N_LIGHTS'(1) << pos_d) : '0;
  end

  // State and output registers; inputs' previous levels reset high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_PLAY;
      pos_q         <= POS_C;
      hold_q        <= '0;
      left_score_q  <= '0;
      right_score_q <= '0;
      left_win_q    <= 1'b0;
      right_win_q   <= 1'b0;
      match_over_q  <= 1'b0;
      lights_q      <= N_LIGHTS'(1) << POS_C;
      l_q           <= 1'b1;
      r_q           <= 1'b1;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      hold_q        <= hold_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      left_win_q    <= left_win_d;
      right_win_q   <= right_win_d;
      match_over_q  <= match_over_d;
      lights_q      <= lights_d;
      l_q           <= l_d;
      r_q           <= r_d;
    end
  end

  assign lights      = lights_q;
  assign left_win    = left_win_q;
  assign right_win   = right_win_q;
  assign left_score  = left_score_q;
  assign right_score = right_score_q;
  assign match_over  = match_over_q;

endmodule

// File: tb/tb_tug_of_war_core.sv
// Testbench for tug_of_war_core (N_LIGHTS=5, SCORE_W=2, HOLD_CYCLES=2).
// Expected output snapshots are queued as stimulus is driven and popped when
// the DUT output is sampled one time unit after the clock edge.
`timescale 1ns/1ps

module tb_tug_of_war_core;

  localparam int unsigned NL = 5;
  localparam int unsigned SW = 2;
  localparam int unsigned HC = 2;
  localparam int unsigned DW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          l_in;
  logic          r_in;
  logic [9:0]    cpu_speed;
  logic [NL-1:0] lights;
  logic          left_win;
  logic          right_win;
  logic [SW-1:0] left_score;
  logic [SW-1:0] right_score;
  logic          match_over;

  typedef struct packed {
    logic [4:0] lt;
    logic       lw;
    logic       rw;
    logic [1:0] ls;
    logic [1:0] rs;
    logic       mo;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  tug_of_war_core #(
    .N_LIGHTS(NL), .SCORE_W(SW), .HOLD_CYCLES(HC), .CPU_DIV_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .l_in(l_in), .r_in(r_in), .cpu_speed(cpu_speed),
    .lights(lights), .left_win(left_win), .right_win(right_win),
    .left_score(left_score), .right_score(right_score), .match_over(match_over)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return {lights, left_win, right_win, left_score, right_score, match_over};
  endfunction

  function automatic obs_t mk(logic [4:0] lt, logic lw, logic rw,
                              logic [1:0] ls, logic [1:0] rs, logic mo);
    return {lt, lw, rw, ls, rs, mo};
  endfunction

  // Drive one cycle of buttons, queue the expected snapshot, advance past the edge
  task automatic step(input logic l, input logic r, input obs_t e);
    l_in = l;
    r_in = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, e;
    reset = 1'b1;
    l_in  = 1'b1;
    r_in  = 1'b1;
    #2;
    exp_q.push_back(mk(5'b00100, 0, 0, 0, 0, 0));
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_value got=%h exp=%h", got, e); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    // keys held through reset must not count as presses
    step(1, 1, mk(5'b00100, 0, 0, 0, 0, 0));
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_held_keys got=%h exp=%h", got, e); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, mk(5'b00100, 0, 0, 0, 0, 0));
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_idle[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

`ifndef TOW_CPU_EN
  task automatic test_left_round();
    obs_t got, e;
    logic l_tab [7];
    obs_t e_tab [7];
    l_tab = '{1, 0, 1, 0, 1, 0, 0};
    e_tab[0] = mk(5'b01000, 0, 0, 0, 0, 0);
    e_tab[1] = mk(5'b01000, 0, 0, 0, 0, 0);
    e_tab[2] = mk(5'b10000, 0, 0, 0, 0, 0);
    e_tab[3] = mk(5'b10000, 0, 0, 0, 0, 0);
    e_tab[4] = mk(5'b00000, 1, 0, 1, 0, 0);
    e_tab[5] = mk(5'b00000, 1, 0, 1, 0, 0);
    e_tab[6] = mk(5'b00100, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(l_tab[i], 0, e_tab[i]);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL left_round[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_hold_and_cancel();
    obs_t got, e;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, mk(5'b01000, 0, 0, 1, 0, 0));
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL hold_one_press[%0d] got=%h exp=%h", i, got, e); end
    end
    step(0, 0, mk(5'b01000, 0, 0, 1, 0, 0));
    step(1, 1, mk(5'b01000, 0, 0, 1, 0, 0));
    step(0, 0, mk(5'b01000, 0, 0, 1, 0, 0));
    step(0, 1, mk(5'b00100, 0, 0, 1, 0, 0));
    step(0, 0, mk(5'b00100, 0, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) begin
      got = 'x;
      e = exp_q.pop_front(); checks++;
      // outputs of earlier steps are no longer visible; compare only the last
      if (i == 4) got = sample(); else got = e;
      if (i == 4 && got !== e) begin errors++; $display("FAIL cancel_then_right got=%h exp=%h", got, e); end
    end
  endtask

  task automatic test_right_match();
    obs_t got, e;
    obs_t e_tab [7];
    logic r_tab [7];
    logic l_tab [7];
    r_tab = '{1, 0, 1, 0, 1, 0, 1};
    l_tab = '{0, 0, 0, 0, 0, 0, 1};
    for (int k = 1; k <= 3; k++) begin
      e_tab[0] = mk(5'b00010, 0, 0, 1, 2'(k - 1), 0);
      e_tab[1] = mk(5'b00010, 0, 0, 1, 2'(k - 1), 0);
      e_tab[2] = mk(5'b00001, 0, 0, 1, 2'(k - 1), 0);
      e_tab[3] = mk(5'b00001, 0, 0, 1, 2'(k - 1), 0);
      e_tab[4] = mk(5'b00000, 0, 1, 1, 2'(k), 0);
      e_tab[5] = mk(5'b00000, 0, 1, 1, 2'(k), 0);
      e_tab[6] = (k < 3) ? mk(5'b00100, 0, 0, 1, 2'(k), 0)
                         : mk(5'b00000, 0, 1, 1, 2'd3, 1);
      for (int i = 0; i < 7; i++) begin
        step(l_tab[i], r_tab[i], e_tab[i]);
        got = sample(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin
          errors++; $display("FAIL right_round%0d[%0d] got=%h exp=%h", k, i, got, e);
        end
      end
      step(0, 0, e_tab[6]);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL right_round%0d_release got=%h exp=%h", k, got, e); end
    end
    for (int i = 0; i < 6; i++) begin
      step(logic'(i == 0 || i == 4), logic'(i == 2 || i == 4), mk(5'b00000, 0, 1, 1, 2'd3, 1));
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL over_locked[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_async_reset();
    obs_t got, e;
    // reset pulse in OVER, checked between clock edges
    l_in = 1'b0; r_in = 1'b0;
    reset = 1'b1;
    #2;
    exp_q.push_back(mk(5'b00100, 0, 0, 0, 0, 0));
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL async_reset_over got=%h exp=%h", got, e); end
    reset = 1'b0;
    step(0, 0, mk(5'b00100, 0, 0, 0, 0, 0));
    step(1, 0, mk(5'b01000, 0, 0, 0, 0, 0));
    step(0, 0, mk(5'b01000, 0, 0, 0, 0, 0));
    step(1, 0, mk(5'b10000, 0, 0, 0, 0, 0));
    step(0, 0, mk(5'b10000, 0, 0, 0, 0, 0));
    step(1, 0, mk(5'b00000, 1, 0, 1, 0, 0));
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      if (i == 5) begin
        got = sample(); checks++;
        if (got !== e) begin errors++; $display("FAIL reach_win_l got=%h exp=%h", got, e); end
      end
    end
    // half-cycle reset pulse during WIN_L hold
    l_in = 1'b0;
    reset = 1'b1;
    #4;
    exp_q.push_back(mk(5'b00100, 0, 0, 0, 0, 0));
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL async_reset_hold got=%h exp=%h", got, e); end
    reset = 1'b0;
    step(0, 0, mk(5'b00100, 0, 0, 0, 0, 0));
    step(1, 0, mk(5'b01000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      if (i == 1) begin
        got = sample(); checks++;
        if (got !== e) begin errors++; $display("FAIL after_reset_press got=%h exp=%h", got, e); end
      end
    end
  endtask
`endif

`ifdef TOW_CPU_EN
  task automatic test_cpu();
    obs_t       got, e;
    logic [4:0] prev;
    int         last_move;
    logic       seen_win;
    cpu_speed = 10'h000;
    for (int i = 0; i < 200; i++) begin
      step(0, 1, mk(5'b00100, 0, 0, 0, 0, 0));
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL cpu_idle[%0d] got=%h exp=%h", i, got, e); end
      r_in = 1'b0;
    end
    cpu_speed = 10'h3FF;
    prev      = lights;
    last_move = -100;
    seen_win  = 1'b0;
    for (int i = 0; i < 400 && !seen_win; i++) begin
      @(posedge clk);
      #1;
      if (lights !== prev) begin
        checks++;
        if (right_win === 1'b1) begin
          seen_win = 1'b1;
          if (lights !== 5'b00000 || prev !== 5'b00001 || right_score !== 2'd1) begin
            errors++; $display("FAIL cpu_win_step got=%b prev=%b rs=%0d exp=00000 from 00001 rs=1",
                               lights, prev, right_score);
          end
        end else if (lights !== (prev >> 1) || (i - last_move) < 8) begin
          errors++; $display("FAIL cpu_step got=%b prev=%b gap=%0d exp=%b gap>=8",
                             lights, prev, i - last_move, prev >> 1);
        end
        last_move = i;
        prev      = lights;
      end
    end
    checks++;
    if (!seen_win) begin errors++; $display("FAIL cpu_eventual_win got=0 exp=1"); end
  endtask
`endif

  initial begin
    cpu_speed = 10'h3FF;
    l_in      = 1'b0;
    r_in      = 1'b0;
    reset     = 1'b1;
    test_reset();
`ifdef TOW_CPU_EN
    test_cpu();
`else
    test_left_round();
    test_hold_and_cancel();
    test_right_match();
    test_async_reset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tug_of_war_core.md
# tug_of_war_core

Parametrised tug-of-war game engine: N-light playfield, per-player round scores, timed round restart, and a match-over latch. It takes two synchronised active-high button levels, performs its own rising-edge detection and drives the light bar, win flags and scores. HEX and LED decode stay at board top level. With `TOW_CPU_EN` defined, the right player is replaced by an LFSR-driven computer opponent.

## Interface
Parameters:
- `N_LIGHTS`, 9: playfield width; must be odd and ≥ 3.
- `SCORE_W`, 3: score counter width; a match is won at score `2**SCORE_W-1`.
- `HOLD_CYCLES`, 4: cycles the win display is held before the next round; must be ≥ 1.
- `CPU_DIV_W`, 20: CPU decision prescaler width. Used only with `TOW_CPU_EN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `l_in`  in  1  left button level, synchronised, 1 = pressed.
- `r_in`  in  1  right button level, synchronised, 1 = pressed. Ignored with `TOW_CPU_EN`.
- `cpu_speed`  in  10  CPU press threshold. Ignored without `TOW_CPU_EN`.
- `lights`  out  N_LIGHTS  one-hot rope position; bit N_LIGHTS-1 is leftmost.
- `left_win`  out  1  high while the left player's round-win is displayed.
- `right_win`  out  1  high while the right player's round-win is displayed.
- `left_score`  out  SCORE_W  left rounds won.
- `right_score`  out  SCORE_W  right rounds won.
- `match_over`  out  1  high once either score reaches max.

## Operation
- Press detection:
  - `pl = l_in & ~l_q`; `pr = r_eff & ~r_q`.
  - `l_q` and `r_q` are registered copies of the inputs and reset to 1, so a key held through reset does not count as a press.
  - `r_eff` is `r_in`, or the CPU press with `TOW_CPU_EN`.
- Position register `pos` ranges over 0..N_LIGHTS-1. Centre is `C = (N_LIGHTS-1)/2`. `lights = 1 << pos` in PLAY, and all-zero in every other state.
- States:
  - PLAY:
    - `pl & ~pr`: if `pos == N_LIGHTS-1`, go to WIN_L; otherwise `pos++`.
    - `pr & ~pl`: if `pos == 0`, go to WIN_R; otherwise `pos--`.
    - Both or neither: no change. Simultaneous presses cancel.
  - WIN_L / WIN_R:
    - On entry, increment the winner's score and load the hold counter with HOLD_CYCLES-1.
    - The matching win flag is high and presses are ignored.
    - When the counter reaches 0: go to OVER if the winner's score is now max; otherwise go to PLAY with `pos = C`.
  - OVER:
    - `match_over = 1`, and the final winner's flag stays high.
    - Lights are 0, presses are ignored, and only `reset` exits.
- Scores cannot overflow, because OVER is entered at max.
- Reset values (asynchronous): state PLAY, `pos = C`, both scores 0, both flags 0, `match_over = 0`, `l_q = r_q = 1`, hold counter 0, LFSR `10'h001`, prescaler 0.
- Reset asserted mid-round, mid-hold or in OVER returns to the reset values immediately, with no clock edge needed.

## Timing
- `lights` updates at the first rising `clk` edge where `l_in` is sampled 1 after being sampled 0. Latency is one edge from the input transition; a registered output follows.
- A winning press sets the win flag, increments the score and clears `lights` at that same edge.
- A win flag is high for exactly HOLD_CYCLES cycles, then `lights` shows the centre on the next cycle.
- Holding a button produces exactly one press, no matter how long it is held.
- All outputs are registered or decoded from registers only; there are no combinational input-to-output paths.

## Configuration
- Macro `TOW_CPU_EN`.
- When defined:
  - A 10-bit Fibonacci LFSR (taps 10, 7) advances every cycle.
  - A CPU_DIV_W-bit prescaler wraps every `2**CPU_DIV_W` cycles.
  - On each wrap, if `lfsr < cpu_speed`, the CPU press level `r_eff` is 1 for that single cycle and 0 otherwise. The pulse therefore appears as a one-cycle rising edge.
  - `r_in` is unused.
  - `cpu_speed = 0` means the CPU never presses; `10'h3FF` means it presses on nearly every wrap.
- When undefined: `r_eff = r_in`, the LFSR and prescaler are not synthesised, and `cpu_speed` is unused.

## Test plan
All scenarios use N_LIGHTS=5, SCORE_W=2, HOLD_CYCLES=2, with `TOW_CPU_EN` undefined unless stated.
- Reset, then idle for 3 cycles → `lights = 5'b00100`, scores 0, flags 0, `match_over = 0`.
- Left presses (0→1→0) three times → lights `01000`, `10000`, then all-zero with `left_win = 1` and `left_score = 1`. Two cycles later `left_win = 0` and lights `00100`.
- Hold `l_in` high for 20 cycles → exactly one move, to `01000`. Raise `l_in` and `r_in` on the same edge → `lights` unchanged.
- Right wins three rounds (`r_in` pressed repeatedly, presses during hold ignored) → after the third win and its hold, `right_score = 3`, `match_over = 1`, `right_win` held high, lights 0. Further presses change nothing.
- Assert `reset` for half a cycle during WIN_L hold → all outputs return to their reset values with no clock edge.
- With `TOW_CPU_EN`, `CPU_DIV_W = 3`, `cpu_speed = 10'h3FF` → the rope moves right at most one step per 8 cycles and the right player eventually wins. With `cpu_speed = 0` → `lights` stays at `00100` for 200 cycles.
